pu_rf_wb: RTL and testbench
===========================

// Module: pu_rf_wb
// PURPOSE
//   Write-back front end for the PU register file (pu_rf): the single writer driving its wr/waddr/din port.
//   Merges ALU results and out-of-order load returns into the one write port.
//   Tracks pending-load destinations in a scoreboard and forwards same-cycle writes onto the 1-cycle RF read data.
//   Sits between PU execute/load units and pu_rf.
// PARAMETERS
//   WIDTH         32           data width, equal to pu_rf WIDTH
//   DEPTH_NBITS   5            register address bits (32 registers)
//   LQ_DEPTH      4            load-return queue entries; also max outstanding loads
//   PROTECT_MASK  32'h8007FF00 registers (8..18, 31: base pointers) that reject writes
// PORTS
//   clk            in   1            clock
//   `RESET_SIG     in   1            reset, active-high, asynchronous
//   alu_wr_valid   in   1            ALU result valid (no backpressure)
//   alu_waddr      in   DEPTH_NBITS  ALU destination register
//   alu_wdata      in   WIDTH        ALU result
//   ld_issue_valid in   1            load issue request
//   ld_issue_rd    in   DEPTH_NBITS  load destination register
//   ld_issue_ready out  1            load issue accepted this cycle (combinational)
//   ld_ret_valid   in   1            load data return (always accepted)
//   ld_ret_waddr   in   DEPTH_NBITS  return destination
//   ld_ret_data    in   WIDTH        return data
//   raddr0/raddr1  in   DEPTH_NBITS  read addresses, also driven to pu_rf
//   rf_dout0/1     in   WIDTH        pu_rf read data
//   hazard0/1      out  1            raddrN targets a busy register (combinational)
//   fwd_dout0/1    out  WIDTH        forwarded read data, same cycle as rf_doutN
//   wr             out  1            pu_rf write enable (registered)
//   waddr          out  DEPTH_NBITS  pu_rf write address (registered)
//   din            out  WIDTH        pu_rf write data (registered)
//   wr_err         out  1            one-cycle pulse: write dropped (protected or busy target)
// BEHAVIOUR
//   Reset: wr=0, waddr=0, din=0, wr_err=0, busy[*]=0, outstanding=0, LQ empty, forward registers 0.
//   Reset mid-operation drops queued returns and clears the scoreboard; no write is issued in the first cycle after release.
//   Load issue: ld_issue_ready = (outstanding<LQ_DEPTH) & !busy[ld_issue_rd].
//     Valid&ready sets busy[rd] and increments outstanding.
//   Load return: pushed into the LQ FIFO the same cycle. Overflow cannot occur by credit; an overflow is an assertion failure.
//   Arbitration per cycle, evaluated at edge:
//     1. An ALU write has priority. alu_wr_valid in N -> wr=1 in N+1.
//     2. Otherwise LQ head pops and writes. Return in N -> wr no earlier than N+2.
//     3. Otherwise wr=0.
//   LQ pop: clears busy[waddr] and decrements outstanding at the same edge that registers wr.
//     Issue and pop in the same cycle leaves outstanding unchanged.
//   Drop rules: any selected write whose target bit is set in PROTECT_MASK -> wr=0, wr_err=1.
//     An ALU write to a busy register -> dropped, wr_err=1.
//     A dropped LQ pop still clears busy and the credit.
//   hazardN = busy[raddrN]. Issue logic must stall on it; the block does not gate reads.
//   Forwarding: register hitN = wr & (waddr==raddrN), with din captured, in cycle N.
//     In N+1, fwd_doutN = hitN ? captured din : rf_doutN. This covers the write landing on the same edge as the read.
//   Busy set by issue and cleared by pop on the same register in the same cycle is impossible, because issue requires !busy.
// STRUCTURE
//   Package pu_rf_pkg: wb_req_t {waddr, data}, PROTECT_MASK default, register-index constants (8..18, 31).
//   Sub-module pu_rf_wb_fifo: LQ_DEPTH-entry synchronous FIFO of wb_req_t with push/pop/empty/full.
//     Pointers wrap modulo LQ_DEPTH, with a count of LQ_DEPTH_NBITS+1 bits.
//   The top level holds the arbiter, scoreboard (DEPTH bits), credit counter, and forwarding registers.
// TESTING
//   1. ALU write r3=0xDEADBEEF in cycle 5 -> wr=1, waddr=3, din=0xDEADBEEF in cycle 6.
//      A read of r3 in cycle 6 yields fwd_dout0=0xDEADBEEF in cycle 7.
//   2. Issue loads to r1..r4 -> ready=1 four times; a fifth load to r5 -> ready=0.
//      Returns in order 4,2,1,3 -> four writes, busy clears, ready=1 again.
//   3. ALU write and load return in the same cycle -> ALU writes in N+1, load writes in N+2. No data lost.
//   4. ALU write to r9 (base pointer) -> wr=0, wr_err=1 for one cycle; r9 unchanged.
//   5. Outstanding load to r7: hazard0=1 while raddr0=7.
//      An ALU write to r7 -> dropped with wr_err. The load return then writes r7 and hazard0 falls.
//   6. Assert reset with 3 queued returns -> wr=0, busy=0, ld_issue_ready=1 after release, and no stale write.

Source files
------------

// File: rtl/pu_rf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pu_rf_wb_pkg
// Brief   : Shared types and constants for the pu_rf write-back front end.
// Rev     : 1.0  initial release
// ============================================================================
package pu_rf_wb_pkg;

    localparam int c_WIDTH       = 32;
    localparam int c_DEPTH_NBITS = 5;

    // Base-pointer registers r8..r18 and r31 are write-protected.
    localparam int c_REG_BP_LO = 8;
    localparam int c_REG_BP_HI = 18;
    localparam int c_REG_BP_TOP = 31;
    localparam logic [31:0] c_PROTECT_MASK = 32'h8007FF00;

    typedef struct packed {
        logic [c_DEPTH_NBITS-1:0] waddr;
        logic [c_WIDTH-1:0]       data;
    } wb_req_t;

endpackage : pu_rf_wb_pkg
`default_nettype wire

// File: rtl/pu_rf_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pu_rf_wb_fifo
// Brief   : LQ_DEPTH-entry synchronous FIFO of write-back requests.
// Rev     : 1.0  initial release
// ============================================================================
module pu_rf_wb_fifo
    import pu_rf_wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output wb_req_t o_data,
    output logic    o_empty,
    output logic    o_full
);

    localparam int c_PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(LQ_DEPTH) + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(LQ_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(LQ_DEPTH);

    wb_req_t              r_mem [LQ_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    function automatic logic [c_PTR_W-1:0] f_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_CNT_FULL);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Load credits bound the queue occupancy; a push into a full queue is a protocol bug upstream.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));

endmodule : pu_rf_wb_fifo
`default_nettype wire

// File: rtl/pu_rf_wb.sv
`default_nettype none
// ============================================================================
// Module  : pu_rf_wb
// Brief   : pu_rf write-back arbiter, pending-load scoreboard and read forwarding.
// Rev     : 1.0  initial release
// ============================================================================
module pu_rf_wb
    import pu_rf_wb_pkg::*;
#(
    parameter int WIDTH       = c_WIDTH,
    parameter int DEPTH_NBITS = c_DEPTH_NBITS,
    parameter int LQ_DEPTH    = 4,
    parameter logic [(1<<DEPTH_NBITS)-1:0] PROTECT_MASK = c_PROTECT_MASK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_alu_wr_valid,
    input  logic [DEPTH_NBITS-1:0] i_alu_waddr,
    input  logic [WIDTH-1:0]       i_alu_wdata,
    input  logic                   i_ld_issue_valid,
    input  logic [DEPTH_NBITS-1:0] i_ld_issue_rd,
    output logic                   o_ld_issue_ready,
    input  logic                   i_ld_ret_valid,
    input  logic [DEPTH_NBITS-1:0] i_ld_ret_waddr,
    input  logic [WIDTH-1:0]       i_ld_ret_data,
    input  logic [DEPTH_NBITS-1:0] i_raddr0,
    input  logic [DEPTH_NBITS-1:0] i_raddr1,
    input  logic [WIDTH-1:0]       i_rf_dout0,
    input  logic [WIDTH-1:0]       i_rf_dout1,
    output logic                   o_hazard0,
    output logic                   o_hazard1,
    output logic [WIDTH-1:0]       o_fwd_dout0,
    output logic [WIDTH-1:0]       o_fwd_dout1,
    output logic                   o_wr,
    output logic [DEPTH_NBITS-1:0] o_waddr,
    output logic [WIDTH-1:0]       o_din,
    output logic                   o_wr_err
);

    localparam int c_DEPTH = 1 << DEPTH_NBITS;
    localparam int c_CNT_W = $clog2(LQ_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_CREDITS = c_CNT_W'(LQ_DEPTH);

    logic [c_DEPTH-1:0]     r_busy;
    logic [c_CNT_W-1:0]     r_outstanding;
    logic                   r_wr;
    logic [DEPTH_NBITS-1:0] r_waddr;
    logic [WIDTH-1:0]       r_din;
    logic                   r_wr_err;
    logic                   r_hit0;
    logic                   r_hit1;
    logic [WIDTH-1:0]       r_fwd0;
    logic [WIDTH-1:0]       r_fwd1;

    wb_req_t                w_ret_req;
    wb_req_t                w_lq_head;
    logic                   w_lq_empty;
    logic                   w_lq_full;
    logic                   w_lq_pop;
    logic                   w_issue_fire;
    logic                   w_sel_valid;
    logic [DEPTH_NBITS-1:0] w_sel_addr;
    logic [WIDTH-1:0]       w_sel_data;
    logic                   w_drop;
    logic                   w_wr_next;
    logic [c_DEPTH-1:0]     w_busy_set;
    logic [c_DEPTH-1:0]     w_busy_clr;

    assign w_ret_req.waddr = i_ld_ret_waddr;
    assign w_ret_req.data  = i_ld_ret_data;

    pu_rf_wb_fifo #(
        .LQ_DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_ld_ret_valid),
        .i_data  (w_ret_req),
        .i_pop   (w_lq_pop),
        .o_data  (w_lq_head),
        .o_empty (w_lq_empty),
        .o_full  (w_lq_full)
    );

    assign o_ld_issue_ready = (r_outstanding < c_CREDITS) & ~r_busy[i_ld_issue_rd];
    assign w_issue_fire     = i_ld_issue_valid & o_ld_issue_ready;
    assign w_lq_pop         = ~i_alu_wr_valid & ~w_lq_empty;

    // ALU wins the port; a dropped load pop still retires its scoreboard entry and credit.
    always_comb begin
        w_sel_valid = i_alu_wr_valid | w_lq_pop;
        w_sel_addr  = i_alu_wr_valid ? i_alu_waddr : w_lq_head.waddr;
        w_sel_data  = i_alu_wr_valid ? i_alu_wdata : w_lq_head.data;
        w_drop      = w_sel_valid &
                      (PROTECT_MASK[w_sel_addr] | (i_alu_wr_valid & r_busy[i_alu_waddr]));
        w_wr_next   = w_sel_valid & ~w_drop;
        w_busy_set  = '0;
        w_busy_clr  = '0;
        if (w_issue_fire) w_busy_set[i_ld_issue_rd]   = 1'b1;
        if (w_lq_pop)     w_busy_clr[w_lq_head.waddr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= '0;
            r_outstanding <= '0;
            r_wr          <= 1'b0;
            r_waddr       <= '0;
            r_din         <= '0;
            r_wr_err      <= 1'b0;
        end else begin
            r_busy   <= (r_busy & ~w_busy_clr) | w_busy_set;
            r_wr     <= w_wr_next;
            r_wr_err <= w_drop;
            if (w_wr_next) begin
                r_waddr <= w_sel_addr;
                r_din   <= w_sel_data;
            end
            case ({w_issue_fire, w_lq_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // pu_rf read data lags its address by one cycle, so a write landing on that edge is replayed here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit0 <= 1'b0;
            r_hit1 <= 1'b0;
            r_fwd0 <= '0;
            r_fwd1 <= '0;
        end else begin
            r_hit0 <= r_wr & (r_waddr == i_raddr0);
            r_hit1 <= r_wr & (r_waddr == i_raddr1);
            r_fwd0 <= r_din;
            r_fwd1 <= r_din;
        end
    end

    assign o_hazard0   = r_busy[i_raddr0];
    assign o_hazard1   = r_busy[i_raddr1];
    assign o_fwd_dout0 = r_hit0 ? r_fwd0 : i_rf_dout0;
    assign o_fwd_dout1 = r_hit1 ? r_fwd1 : i_rf_dout1;
    assign o_wr        = r_wr;
    assign o_waddr     = r_waddr;
    assign o_din       = r_din;
    assign o_wr_err    = r_wr_err;

endmodule : pu_rf_wb
`default_nettype wire

// File: tb/tb_pu_rf_wb.sv
`default_nettype none
// ============================================================================
// Module  : tb_pu_rf_wb
// Brief   : Scoreboard bench for pu_rf_wb: directed scenarios plus random traffic.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pu_rf_wb;

    localparam int c_LQ = 4;
    localparam bit [31:0] c_PROT = 32'h8007FF00;

    typedef struct {
        int        cyc;
        bit        err;
        bit [4:0]  a;
        bit [31:0] d;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_alu_wr_valid = 1'b0;
    logic [4:0]  i_alu_waddr = '0;
    logic [31:0] i_alu_wdata = '0;
    logic        i_ld_issue_valid = 1'b0;
    logic [4:0]  i_ld_issue_rd = '0;
    logic        o_ld_issue_ready;
    logic        i_ld_ret_valid = 1'b0;
    logic [4:0]  i_ld_ret_waddr = '0;
    logic [31:0] i_ld_ret_data = '0;
    logic [4:0]  i_raddr0 = '0;
    logic [4:0]  i_raddr1 = '0;
    logic [31:0] i_rf_dout0 = '0;
    logic [31:0] i_rf_dout1 = '0;
    logic        o_hazard0, o_hazard1;
    logic [31:0] o_fwd_dout0, o_fwd_dout1;
    logic        o_wr;
    logic [4:0]  o_waddr;
    logic [31:0] o_din;
    logic        o_wr_err;

    pu_rf_wb #(.WIDTH(32), .DEPTH_NBITS(5), .LQ_DEPTH(c_LQ), .PROTECT_MASK(c_PROT)) dut (
        .clk(clk), .rst(rst),
        .i_alu_wr_valid(i_alu_wr_valid), .i_alu_waddr(i_alu_waddr), .i_alu_wdata(i_alu_wdata),
        .i_ld_issue_valid(i_ld_issue_valid), .i_ld_issue_rd(i_ld_issue_rd),
        .o_ld_issue_ready(o_ld_issue_ready),
        .i_ld_ret_valid(i_ld_ret_valid), .i_ld_ret_waddr(i_ld_ret_waddr), .i_ld_ret_data(i_ld_ret_data),
        .i_raddr0(i_raddr0), .i_raddr1(i_raddr1), .i_rf_dout0(i_rf_dout0), .i_rf_dout1(i_rf_dout1),
        .o_hazard0(o_hazard0), .o_hazard1(o_hazard1),
        .o_fwd_dout0(o_fwd_dout0), .o_fwd_dout1(o_fwd_dout1),
        .o_wr(o_wr), .o_waddr(o_waddr), .o_din(o_din), .o_wr_err(o_wr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: scoreboard of pending destinations, credits, return queue.
    ev_t       sb[$];
    ev_t       lq[$];
    bit [4:0]  pending[$];
    bit [31:0] busy = '0;
    int        outst = 0;
    bit        nxt_wr = 0, cur_wr = 0;
    bit [4:0]  nxt_a = '0, cur_a = '0;
    bit [31:0] nxt_d = '0, cur_d = '0;
    bit        hit0 = 0, hit1 = 0;
    bit [31:0] hd0 = '0, hd1 = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT write or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missed_event: err=%0d addr=%0d data=%h due cycle %0d not seen",
                         e.err, e.a, e.d, e.cyc);
            end
            if (o_wr || o_wr_err) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: wr=%0d err=%0d addr=%0d data=%h cycle %0d, none expected",
                             o_wr, o_wr_err, o_waddr, o_din, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cyc || o_wr_err != e.err || o_wr != !e.err ||
                        (!e.err && (o_waddr != e.a || o_din != e.d))) begin
                        n_fail++;
                        $display("FAIL wb_event: got wr=%0d err=%0d addr=%0d data=%h cycle %0d, expected err=%0d addr=%0d data=%h cycle %0d",
                                 o_wr, o_wr_err, o_waddr, o_din, cyc, e.err, e.a, e.d, e.cyc);
                    end
                end
            end
        end
    end

    task automatic step(input bit av, input bit [4:0] aa, input bit [31:0] ad,
                        input bit iv, input bit [4:0] ir,
                        input bit rv, input bit [4:0] ra, input bit [31:0] rdat,
                        input bit [4:0] r0, input bit [4:0] r1);
        bit [31:0] x0, x1, f0, f1;
        bit        m_ready;
        ev_t       e;
        @(posedge clk);
        #1;
        cur_wr = nxt_wr; cur_a = nxt_a; cur_d = nxt_d;
        x0 = $urandom; x1 = $urandom;
        i_alu_wr_valid = av; i_alu_waddr = aa; i_alu_wdata = ad;
        i_ld_issue_valid = iv; i_ld_issue_rd = ir;
        i_ld_ret_valid = rv; i_ld_ret_waddr = ra; i_ld_ret_data = rdat;
        i_raddr0 = r0; i_raddr1 = r1; i_rf_dout0 = x0; i_rf_dout1 = x1;
        f0 = hit0 ? hd0 : x0;
        f1 = hit1 ? hd1 : x1;
        m_ready = (outst < c_LQ) && !busy[ir];
        #2;
        chk("ld_issue_ready", {31'd0, o_ld_issue_ready}, {31'd0, m_ready});
        chk("hazard0", {31'd0, o_hazard0}, {31'd0, busy[r0]});
        chk("hazard1", {31'd0, o_hazard1}, {31'd0, busy[r1]});
        chk("fwd_dout0", o_fwd_dout0, f0);
        chk("fwd_dout1", o_fwd_dout1, f1);
        // Advance the model to the edge that ends this cycle.
        hit0 = cur_wr && cur_a == r0; hd0 = cur_d;
        hit1 = cur_wr && cur_a == r1; hd1 = cur_d;
        nxt_wr = 0;
        if (av) begin
            e.cyc = cyc + 1; e.a = aa; e.d = ad;
            e.err = c_PROT[aa] || busy[aa];
            sb.push_back(e);
            if (!e.err) begin nxt_wr = 1; nxt_a = aa; nxt_d = ad; end
        end else if (lq.size() > 0) begin
            e = lq.pop_front();
            busy[e.a] = 0;
            outst--;
            e.cyc = cyc + 1;
            e.err = c_PROT[e.a];
            sb.push_back(e);
            if (!e.err) begin nxt_wr = 1; nxt_a = e.a; nxt_d = e.d; end
        end
        if (rv) begin
            e.cyc = 0; e.err = 0; e.a = ra; e.d = rdat;
            lq.push_back(e);
        end
        if (iv && m_ready) begin
            busy[ir] = 1;
            outst++;
            pending.push_back(ir);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 5'($urandom), 5'($urandom));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        i_alu_wr_valid = 0; i_ld_issue_valid = 0; i_ld_ret_valid = 0;
        i_ld_issue_rd = 5'd20;
        sb.delete(); lq.delete(); pending.delete();
        busy = '0; outst = 0; nxt_wr = 0; hit0 = 0; hit1 = 0;
        #2;
        chk("reset_wr", {31'd0, o_wr}, 32'd0);
        chk("reset_wr_err", {31'd0, o_wr_err}, 32'd0);
        chk("reset_waddr", {27'd0, o_waddr}, 32'd0);
        chk("reset_din", o_din, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        #2;
        chk("post_reset_ready", {31'd0, o_ld_issue_ready}, 32'd1);
    endtask

    initial begin
        bit        av, iv, rv;
        bit [4:0]  ra;
        int        idx;
        do_reset();

        // ALU write then same-edge read of r3 gets forwarded data.
        step(1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd0, 5'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
        idle(2);

        // Four loads fill the credits, fifth stalls, out-of-order returns drain them.
        for (int r = 1; r <= 4; r++) step(0, 0, 0, 1, 5'(r), 0, 0, 0, 5'(r), 5'd0);
        step(0, 0, 0, 1, 5'd5, 0, 0, 0, 5'd4, 5'd2);
        step(0, 0, 0, 0, 0, 1, 5'd4, 32'h4444_0004, 5'd4, 5'd2);
        step(0, 0, 0, 0, 0, 1, 5'd2, 32'h2222_0002, 5'd4, 5'd2);
        step(0, 0, 0, 0, 0, 1, 5'd1, 32'h1111_0001, 5'd1, 5'd3);
        step(0, 0, 0, 0, 0, 1, 5'd3, 32'h3333_0003, 5'd1, 5'd3);
        idle(3);
        step(0, 0, 0, 1, 5'd5, 0, 0, 0, 5'd5, 5'd0);
        step(0, 0, 0, 0, 0, 1, 5'd5, 32'h5555_0005, 5'd5, 5'd0);
        idle(2);

        // ALU and load return in the same cycle.
        step(0, 0, 0, 1, 5'd20, 0, 0, 0, 5'd20, 5'd21);
        step(1, 5'd21, 32'hA1A1_0021, 0, 0, 1, 5'd20, 32'hB0B0_0020, 5'd20, 5'd21);
        idle(3);

        // Protected target, then ALU write to a register with a load in flight.
        step(1, 5'd9, 32'h0000_0999, 0, 0, 0, 0, 0, 5'd9, 5'd31);
        step(1, 5'd31, 32'h0000_3131, 0, 0, 0, 0, 0, 5'd9, 5'd31);
        step(0, 0, 0, 1, 5'd7, 0, 0, 0, 5'd7, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd7);
        step(1, 5'd7, 32'hBAD0_0007, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        step(0, 0, 0, 0, 0, 1, 5'd7, 32'h7777_0007, 5'd7, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd0);
        idle(3);

        // Reset with three returns queued behind ALU traffic.
        for (int r = 20; r <= 22; r++) step(0, 0, 0, 1, 5'(r), 0, 0, 0, 5'(r), 5'd0);
        for (int r = 20; r <= 22; r++)
            step(1, 5'd2, 32'hC0DE_0000 + 32'(r), 0, 0, 1, 5'(r), 32'hF00D_0000 + 32'(r), 5'd20, 5'd0);
        do_reset();
        idle(3);
        step(0, 0, 0, 1, 5'd20, 0, 0, 0, 5'd20, 5'd22);
        step(0, 0, 0, 0, 0, 1, 5'd20, 32'h2020_2020, 5'd20, 5'd22);
        idle(3);
        do_reset();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            av = ($urandom % 4) == 0;
            iv = ($urandom % 3) == 0;
            rv = 0; ra = '0;
            if (pending.size() > 0 && ($urandom % 2) == 1) begin
                idx = $urandom_range(0, pending.size() - 1);
                ra = pending[idx];
                pending.delete(idx);
                rv = 1;
            end
            step(av, 5'($urandom), $urandom, iv, 5'($urandom), rv, ra, $urandom,
                 5'($urandom), 5'($urandom));
        end
        while (pending.size() > 0) begin
            ra = pending.pop_front();
            step(0, 0, 0, 0, 0, 1, ra, $urandom, 5'($urandom), 5'($urandom));
        end
        idle(8);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pu_rf_wb
`default_nettype wire
